// File: rtl/riscv_defs.sv
// riscv_defs: shared RV32I definitions used by the load/store unit.
// Holds the ld/st funct3 encodings, the LSU state and access-size enums,
// and small helpers that decode an access size and check its alignment.
package riscv_defs;

    // RV32I load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // RV32I store funct3 encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Default data word width and the matching byte-enable count
    localparam int unsigned LSU_NB_WORD = 32;
    localparam int unsigned NB_BE       = LSU_NB_WORD / 8;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_RESP
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } lsu_size_t;

    // Any funct3 that is not a known byte/half encoding is a word access
    function automatic lsu_size_t lsu_size(input logic we, input logic [2:0] funct3);
        lsu_size_t s;
        s = SZ_WORD;
        if (we) begin
            case (funct3)
                F3_SB:   s = SZ_BYTE;
                F3_SH:   s = SZ_HALF;
                default: s = SZ_WORD;
            endcase
        end else begin
            case (funct3)
                F3_LB, F3_LBU: s = SZ_BYTE;
                F3_LH, F3_LHU: s = SZ_HALF;
                default:       s = SZ_WORD;
            endcase
        end
        return s;
    endfunction

    // Halves need an even address, words a multiple of four
    function automatic logic lsu_misaligned(input lsu_size_t s, input logic [1:0] addrLow);
        logic m;
        case (s)
            SZ_HALF: m = addrLow[0];
            SZ_WORD: m = (addrLow != 2'b00);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: handshaked data-memory bus between the LSU (master)
// and the memory (slave). The request side is held stable until ack; read
// data is valid in the same cycle as ack.
interface load_store_unit_if #(
    parameter int unsigned NB_WORD = 32,
    parameter int unsigned NB_ADDR = 32
);
    logic                   mem_req;
    logic                   mem_we;
    logic [NB_ADDR-1:0]     mem_addr;
    logic [NB_WORD/8-1:0]   mem_be;
    logic [NB_WORD-1:0]     mem_wdata;
    logic                   mem_ack;
    logic [NB_WORD-1:0]     mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: purely combinational byte-lane steering for the LSU.
// Stores: byte enables plus store data replicated across the lanes.
// Loads: the read word shifted down by the lane, then sign/zero-extended.
module lsu_lane_align
    import riscv_defs::*;
#(
    parameter int unsigned NB_WORD = 32,
    parameter int unsigned NB_LANE = $clog2(NB_WORD / 8)
) (
    input  logic                 i_we,
    input  logic [2:0]           i_funct3,
    input  logic [NB_LANE-1:0]   i_lane,
    input  logic [NB_WORD-1:0]   i_wr_data,
    input  logic [NB_WORD-1:0]   i_rd_word,
    output logic [NB_WORD/8-1:0] o_be,
    output logic [NB_WORD-1:0]   o_wdata,
    output logic [NB_WORD-1:0]   o_rd_data
);
    localparam int unsigned NB_BYTES = NB_WORD / 8;

    lsu_size_t              w_size;
    logic [NB_WORD-1:0]     w_shift;

    assign w_size  = lsu_size(i_we, i_funct3);
    assign w_shift = i_rd_word >> {i_lane, 3'b000};

    // Store side: enables follow the access size; each lane takes the byte of
    // the right-justified store data it would hold if the datum were replicated
    always_comb begin
        o_be    = '0;
        o_wdata = '0;
        if (i_we) begin
            case (w_size)
                SZ_BYTE: o_be = NB_BYTES'(1) << i_lane;
                SZ_HALF: o_be = NB_BYTES'(3) << i_lane;
                default: o_be = NB_BYTES'(4'hF) << i_lane;
            endcase
            for (int k = 0; k < int'(NB_BYTES); k++) begin
                case (w_size)
                    SZ_BYTE: o_wdata[k*8 +: 8] = i_wr_data[7:0];
                    SZ_HALF: o_wdata[k*8 +: 8] = i_wr_data[(k%2)*8 +: 8];
                    default: o_wdata[k*8 +: 8] = i_wr_data[(k%4)*8 +: 8];
                endcase
            end
        end else begin
            o_be = '1;
        end
    end

    // Load side: extend the lane-shifted word; unknown encodings pass through
    always_comb begin
        case (i_funct3)
            F3_LB:   o_rd_data = {{(NB_WORD-8){w_shift[7]}}, w_shift[7:0]};
            F3_LBU:  o_rd_data = {{(NB_WORD-8){1'b0}}, w_shift[7:0]};
            F3_LH:   o_rd_data = {{(NB_WORD-16){w_shift[15]}}, w_shift[15:0]};
            F3_LHU:  o_rd_data = {{(NB_WORD-16){1'b0}}, w_shift[15:0]};
            default: o_rd_data = w_shift;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: data-memory load/store unit between EX/MEM and a
// handshaked data bus. Accepts one access at a time, steers bytes through
// lsu_lane_align, and runs an IDLE -> REQ -> RESP transaction FSM so the
// memory may take any number of cycles; the pipeline stalls on o_busy.
// Optional feature: define LSU_TIMEOUT_EN to abort a bus request that sees
// no ack within TIMEOUT_CYCLES cycles and report it through o_bus_err.
module load_store_unit
    import riscv_defs::*;
#(
    parameter int unsigned NB_WORD        = 32,
    parameter int unsigned NB_ADDR        = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_req,
    input  logic                i_we,
    input  logic [2:0]          i_funct3,
    input  logic [NB_ADDR-1:0]  i_addr,
    input  logic [NB_WORD-1:0]  i_wr_data,
    output logic                o_busy,
    output logic                o_done,
    output logic [NB_WORD-1:0]  o_rd_data,
    output logic                o_misaligned,
    output logic                o_bus_err,
    load_store_unit_if.master   bus
);
    localparam int unsigned NB_LANE = $clog2(NB_WORD / 8);

    if ((NB_WORD % 8 != 0) || (NB_WORD < 32) || (TIMEOUT_CYCLES < 1)) begin : g_bad_params
        $error("load_store_unit: NB_WORD must be a multiple of 8 and >= 32, TIMEOUT_CYCLES >= 1");
    end

    lsu_state_t             r_state;
    lsu_state_t             w_next_state;
    logic                   r_we;
    logic [2:0]             r_funct3;
    logic [NB_ADDR-1:0]     r_addr;
    logic [NB_WORD-1:0]     r_wdata;
    logic                   r_mem_req;
    logic [NB_WORD-1:0]     r_rd_data;
    logic                   r_misaligned;

    logic                   w_accept;
    logic                   w_misaligned_in;
    logic                   w_timeout;
    logic [NB_WORD/8-1:0]   w_be;
    logic [NB_WORD-1:0]     w_wdata;
    logic [NB_WORD-1:0]     w_rd_data;

    assign w_accept        = (r_state == LSU_IDLE) && i_req;
    assign w_misaligned_in = lsu_misaligned(lsu_size(i_we, i_funct3), i_addr[1:0]);

    lsu_lane_align #(
        .NB_WORD (NB_WORD),
        .NB_LANE (NB_LANE)
    ) u_lane_align (
        .i_we      (r_we),
        .i_funct3  (r_funct3),
        .i_lane    (r_addr[NB_LANE-1:0]),
        .i_wr_data (r_wdata),
        .i_rd_word (bus.mem_rdata),
        .o_be      (w_be),
        .o_wdata   (w_wdata),
        .o_rd_data (w_rd_data)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned NB_CNT = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [NB_CNT-1:0]      r_count;
    logic                   r_bus_err;

    // The limit only fires when no ack arrives in that same cycle
    assign w_timeout = (r_state == LSU_REQ) && !bus.mem_ack &&
                       (r_count == NB_CNT'(TIMEOUT_CYCLES - 1));

    // Count REQ cycles, restarting from zero on every accepted bus access
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (w_accept) begin
            r_count <= '0;
        end else if (r_state == LSU_REQ) begin
            r_count <= r_count + NB_CNT'(1);
        end
    end

    // Bus-error flag: cleared on acceptance, set when the wait limit expires
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_bus_err <= 1'b0;
        end else if (w_accept) begin
            r_bus_err <= 1'b0;
        end else if (w_timeout) begin
            r_bus_err <= 1'b1;
        end
    end

    assign o_bus_err = (r_state == LSU_RESP) && r_bus_err;
`else
    assign w_timeout = 1'b0;
    assign o_bus_err = 1'b0;
`endif

    // State register
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= LSU_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: misaligned accesses skip the bus and report straight away
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            LSU_IDLE: begin
                if (i_req) begin
                    w_next_state = w_misaligned_in ? LSU_RESP : LSU_REQ;
                end
            end
            LSU_REQ: begin
                if (bus.mem_ack || w_timeout) begin
                    w_next_state = LSU_RESP;
                end
            end
            LSU_RESP: w_next_state = LSU_IDLE;
            default:  w_next_state = LSU_IDLE;
        endcase
    end

    // Access registers: latch the request on acceptance, end the bus cycle on
    // ack or timeout, and capture the extended load data (zero otherwise)
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_we         <= 1'b0;
            r_funct3     <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_mem_req    <= 1'b0;
            r_rd_data    <= '0;
            r_misaligned <= 1'b0;
        end else if (w_accept) begin
            r_we         <= i_we;
            r_funct3     <= i_funct3;
            r_addr       <= i_addr;
            r_wdata      <= i_wr_data;
            r_misaligned <= w_misaligned_in;
            r_mem_req    <= !w_misaligned_in;
            if (w_misaligned_in) begin
                r_rd_data <= '0;
            end
        end else if (r_state == LSU_REQ) begin
            if (bus.mem_ack) begin
                r_mem_req <= 1'b0;
                r_rd_data <= r_we ? '0 : w_rd_data;
            end else if (w_timeout) begin
                r_mem_req <= 1'b0;
                r_rd_data <= '0;
            end
        end
    end

    // Bus outputs are only non-zero while a request is actually on the bus
    always_comb begin
        bus.mem_req   = r_mem_req;
        bus.mem_we    = r_mem_req && r_we;
        bus.mem_addr  = r_mem_req ? {r_addr[NB_ADDR-1:NB_LANE], {NB_LANE{1'b0}}} : '0;
        bus.mem_be    = r_mem_req ? w_be : '0;
        bus.mem_wdata = r_mem_req ? w_wdata : '0;
    end

    assign o_busy       = (r_state != LSU_IDLE);
    assign o_done       = (r_state == LSU_RESP);
    assign o_misaligned = (r_state == LSU_RESP) && r_misaligned;
    assign o_rd_data    = r_rd_data;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed self-checking bench for load_store_unit.
// Cycle numbering inside applyStimulus: the cycle in which i_req is raised
// is cycle 1; outputs are sampled 1 time unit after each rising edge.
// Timeout cases are compiled in when LSU_TIMEOUT_EN is defined.
module tb_load_store_unit;
    import riscv_defs::*;

    logic        clock;
    logic        reset;
    logic        iReq;
    logic        iWe;
    logic [2:0]  iFunct3;
    logic [31:0] iAddr;
    logic [31:0] iWrData;
    logic        oBusy;
    logic        oDone;
    logic [31:0] oRdData;
    logic        oMisaligned;
    logic        oBusErr;

    int checks;
    int errors;

    // Per-transaction observations recorded by applyStimulus
    logic        seenReq;
    logic        stableOk;
    int          reqCycles;
    int          doneCycle;
    int          ackCycle;
    logic [31:0] snapAddr;
    logic [3:0]  snapBe;
    logic [31:0] snapWdata;
    logic        snapWe;
    logic [31:0] obsRd;
    logic        obsMis;
    logic        obsErr;
    logic        obsReqAtDone;

    load_store_unit_if #(.NB_WORD(32), .NB_ADDR(32)) bus ();

    load_store_unit #(
        .NB_WORD        (32),
        .NB_ADDR        (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .i_clock      (clock),
        .i_reset      (reset),
        .i_req        (iReq),
        .i_we         (iWe),
        .i_funct3     (iFunct3),
        .i_addr       (iAddr),
        .i_wr_data    (iWrData),
        .o_busy       (oBusy),
        .o_done       (oDone),
        .o_rd_data    (oRdData),
        .o_misaligned (oMisaligned),
        .o_bus_err    (oBusErr),
        .bus          (bus.master)
    );

    // 10-unit clock period
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hard stop in case anything wedges
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no end of test, expected finish before time 200000");
        $fatal(1);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Issue one request and play the memory: ack arrives after ackDelay
    // REQ cycles (negative = never), then wait for o_done
    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int ackDelay, input logic [31:0] rdata);
        int   waited;
        logic gotDone;
        waited   = 0;
        gotDone  = 1'b0;
        seenReq  = 1'b0;
        stableOk = 1'b1;
        reqCycles = 0;
        doneCycle = 0;
        ackCycle  = 0;
        iReq    = 1'b1;
        iWe     = we;
        iFunct3 = f3;
        iAddr   = addr;
        iWrData = wdata;
        for (int c = 2; c < 60 && !gotDone; c++) begin
            step();
            iReq = 1'b0;
            if (bus.mem_ack) begin
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = '0;
            end
            if (oDone) begin
                gotDone      = 1'b1;
                doneCycle    = c;
                obsRd        = oRdData;
                obsMis       = oMisaligned;
                obsErr       = oBusErr;
                obsReqAtDone = bus.mem_req;
            end else if (bus.mem_req) begin
                if (!seenReq) begin
                    seenReq   = 1'b1;
                    snapAddr  = bus.mem_addr;
                    snapBe    = bus.mem_be;
                    snapWdata = bus.mem_wdata;
                    snapWe    = bus.mem_we;
                end else if (snapAddr !== bus.mem_addr || snapBe !== bus.mem_be ||
                             snapWdata !== bus.mem_wdata || snapWe !== bus.mem_we) begin
                    stableOk = 1'b0;
                end
                reqCycles++;
                if (waited == ackDelay) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = rdata;
                    ackCycle      = c;
                end
                waited++;
            end
        end
        checkOutput("done_seen", 32'(gotDone), 32'd1);
    endtask

    // One cycle after o_done the unit must be idle again
    task automatic checkIdleAfter(input string tag);
        step();
        checkOutput({tag, "_done_drop"}, 32'(oDone), 32'd0);
        checkOutput({tag, "_idle"}, 32'(oBusy), 32'd0);
    endtask

    initial begin
        logic doneDuringReset;
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        iReq          = 1'b0;
        iWe           = 1'b0;
        iFunct3       = 3'b000;
        iAddr         = '0;
        iWrData       = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;

        // Reset state
        #3;
        checkOutput("rst_busy",    32'(oBusy), 32'd0);
        checkOutput("rst_done",    32'(oDone), 32'd0);
        checkOutput("rst_rd_data", oRdData, 32'h0);
        checkOutput("rst_mem_req", 32'(bus.mem_req), 32'd0);
        checkOutput("rst_mem_be",  32'(bus.mem_be), 32'h0);
        checkOutput("rst_mem_adr", bus.mem_addr, 32'h0);
        step();
        reset = 1'b0;
        step();

        // 1. SB to lane 3, ack after two waiting REQ cycles
        applyStimulus(1'b1, F3_SB, 32'h0000_0103, 32'h0000_00AB, 2, 32'h0);
        checkOutput("sb_be",     32'(snapBe), 32'h8);
        checkOutput("sb_wdata",  snapWdata, 32'hABAB_ABAB);
        checkOutput("sb_addr",   snapAddr, 32'h0000_0100);
        checkOutput("sb_we",     32'(snapWe), 32'd1);
        checkOutput("sb_stable", 32'(stableOk), 32'd1);
        checkOutput("sb_ackcyc", 32'(ackCycle), 32'd4);
        checkOutput("sb_donecyc", 32'(doneCycle), 32'd5);
        checkOutput("sb_req_drop", 32'(obsReqAtDone), 32'd0);
        checkOutput("sb_mis",    32'(obsMis), 32'd0);
        checkOutput("sb_err",    32'(obsErr), 32'd0);
        checkIdleAfter("sb");

        // 2. LB / LBU from lane 2, same-cycle ack
        applyStimulus(1'b0, F3_LB, 32'h0000_0102, 32'h0, 0, 32'h0080_0000);
        checkOutput("lb_data",   obsRd, 32'hFFFF_FF80);
        checkOutput("lb_donecyc", 32'(doneCycle), 32'd3);
        checkOutput("lb_be",     32'(snapBe), 32'hF);
        checkOutput("lb_we",     32'(snapWe), 32'd0);
        checkOutput("lb_addr",   snapAddr, 32'h0000_0100);
        checkIdleAfter("lb");
        applyStimulus(1'b0, F3_LBU, 32'h0000_0102, 32'h0, 0, 32'h0080_0000);
        checkOutput("lbu_data",  obsRd, 32'h0000_0080);
        checkOutput("lbu_donecyc", 32'(doneCycle), 32'd3);
        checkIdleAfter("lbu");

        // rd_data holds between completions
        step();
        checkOutput("rd_hold", oRdData, 32'h0000_0080);

        // 3. Misaligned half and word loads never reach the bus
        applyStimulus(1'b0, F3_LH, 32'h0000_0201, 32'h0, 0, 32'h0);
        checkOutput("lh_mis_noreq", 32'(seenReq), 32'd0);
        checkOutput("lh_mis_flag",  32'(obsMis), 32'd1);
        checkOutput("lh_mis_cyc",   32'(doneCycle), 32'd2);
        checkIdleAfter("lh_mis");
        applyStimulus(1'b0, F3_LW, 32'h0000_0202, 32'h0, 0, 32'h0);
        checkOutput("lw_mis_noreq", 32'(seenReq), 32'd0);
        checkOutput("lw_mis_flag",  32'(obsMis), 32'd1);
        checkOutput("lw_mis_cyc",   32'(doneCycle), 32'd2);
        checkIdleAfter("lw_mis");

        // 4. SH to the upper half, LHU from the upper half
        applyStimulus(1'b1, F3_SH, 32'h0000_0002, 32'h0000_1234, 1, 32'h0);
        checkOutput("sh_be",    32'(snapBe), 32'hC);
        checkOutput("sh_wdata", snapWdata, 32'h1234_1234);
        checkOutput("sh_addr",  snapAddr, 32'h0);
        checkIdleAfter("sh");
        applyStimulus(1'b0, F3_LHU, 32'h0000_0002, 32'h0, 0, 32'hBEEF_0000);
        checkOutput("lhu_data", obsRd, 32'h0000_BEEF);
        checkIdleAfter("lhu");

        // Signed half, aligned word, unknown funct3 store (word access)
        applyStimulus(1'b0, F3_LH, 32'h0000_0012, 32'h0, 0, 32'h8001_0000);
        checkOutput("lh_data",  obsRd, 32'hFFFF_8001);
        checkIdleAfter("lh");
        applyStimulus(1'b0, F3_LW, 32'h0000_0010, 32'h0, 3, 32'hDEAD_BEEF);
        checkOutput("lw_data",   obsRd, 32'hDEAD_BEEF);
        checkOutput("lw_reqcyc", 32'(reqCycles), 32'd4);
        checkOutput("lw_stable", 32'(stableOk), 32'd1);
        checkIdleAfter("lw");
        applyStimulus(1'b1, 3'b011, 32'h0000_0020, 32'h1357_9BDF, 0, 32'h0);
        checkOutput("sx_be",    32'(snapBe), 32'hF);
        checkOutput("sx_wdata", snapWdata, 32'h1357_9BDF);
        checkIdleAfter("sx");
        applyStimulus(1'b1, 3'b011, 32'h0000_0021, 32'h0, 0, 32'h0);
        checkOutput("sx_mis", 32'(obsMis), 32'd1);
        checkIdleAfter("sx_mis");

        // 5. Reset while in REQ aborts the access
        iReq    = 1'b1;
        iWe     = 1'b0;
        iFunct3 = F3_LW;
        iAddr   = 32'h0000_0040;
        step();
        iReq = 1'b0;
        checkOutput("rst_mid_req_on", 32'(bus.mem_req), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rst_mid_req_off", 32'(bus.mem_req), 32'd0);
        checkOutput("rst_mid_busy",    32'(oBusy), 32'd0);
        step();
        reset = 1'b0;
        doneDuringReset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            doneDuringReset = doneDuringReset | oDone;
        end
        checkOutput("rst_mid_nodone", 32'(doneDuringReset), 32'd0);
        applyStimulus(1'b0, F3_LW, 32'h0000_0040, 32'h0, 1, 32'h1234_5678);
        checkOutput("rst_after_data", obsRd, 32'h1234_5678);
        checkOutput("rst_after_cyc",  32'(doneCycle), 32'd4);
        checkIdleAfter("rst_after");

`ifdef LSU_TIMEOUT_EN
        // 6. No ack: bus error after four REQ cycles
        applyStimulus(1'b0, F3_LW, 32'h0000_0080, 32'h0, -1, 32'h0);
        checkOutput("to_err",     32'(obsErr), 32'd1);
        checkOutput("to_reqcyc",  32'(reqCycles), 32'd4);
        checkOutput("to_donecyc", 32'(doneCycle), 32'd6);
        checkOutput("to_rd_zero", obsRd, 32'h0);
        checkOutput("to_req_drop", 32'(obsReqAtDone), 32'd0);
        checkIdleAfter("to");
        // Ack in the fourth REQ cycle wins over the limit
        applyStimulus(1'b0, F3_LW, 32'h0000_0080, 32'h0, 3, 32'hCAFE_F00D);
        checkOutput("to_ack_err",  32'(obsErr), 32'd0);
        checkOutput("to_ack_data", obsRd, 32'hCAFE_F00D);
        checkOutput("to_ack_cyc",  32'(doneCycle), 32'd6);
        checkIdleAfter("to_ack");
`else
        // Without the timeout feature a long wait still completes normally
        applyStimulus(1'b0, F3_LW, 32'h0000_0080, 32'h0, 10, 32'hCAFE_F00D);
        checkOutput("long_err",  32'(obsErr), 32'd0);
        checkOutput("long_data", obsRd, 32'hCAFE_F00D);
        checkOutput("long_cyc",  32'(doneCycle), 32'd13);
        checkIdleAfter("long");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
